irq_ctl: RTL

Memory-mapped interrupt controller sitting directly upstream of the 65C02 core's `IRQ` and `NMI` inputs. It synchronises eight external interrupt sources and one NMI source, latches edges and masks them, and presents a single level `IRQ` and `NMI` to the core. Software reads a priority vector, acknowledges edges, and programs masks through a small register window on the core's address/data bus.

---
 rtl/irq_ctl.sv | 114 +++++++++++
 1 files changed

// File: rtl/irq_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_ctl : 8-source IRQ / 1-source NMI controller on the 65C02 bus    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_ctl #(
  parameter logic [15:0] BASE  = 16'hFE00,
  parameter logic [3:0]  VBASE = 4'hF
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [15:0] AD,
  input  logic [7:0]  DI,
  input  logic        WE,
  output logic [7:0]  DO,
  output logic        SEL,
  input  logic [7:0]  SRC,
  input  logic        NMI_SRC,
  output logic        IRQ,
  output logic        NMI
);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;
  localparam logic [2:0] OFF_NMICTL = 3'd4;

  // Bit 8 of the synchroniser chain carries NMI_SRC.
  logic [8:0] s1_q, s2_q, s3_q;
  logic [7:0] lat_q, lat_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] do_q, do_d;
  logic       nmi_q, nmi_d;
  logic       irq_q, irq_d;
  logic       sel_q, sel_d;

  logic [8:0] rise;
  logic [7:0] pend, qual, vector, clr;
  logic       win, wr, rd;
  logic [2:0] off;

  always_comb begin
    rise = s2_q & ~s3_q;
    win  = (AD[15:3] == BASE[15:3]);
    off  = AD[2:0];
    wr   = win & WE;
    rd   = win & ~WE;

    pend = (edge_q & lat_q) | (~edge_q & s2_q[7:0]);
    qual = pend & enable_q;

    // Descending scan so the lowest qualifying index is the one that sticks.
    vector = {VBASE, 4'hF};
    for (int i = 7; i >= 0; i--) begin
      if (qual[i]) vector = {VBASE, i[2:0], 1'b0};
    end

    clr      = (wr && off == OFF_STATUS) ? DI : 8'h00;
    // Set beats clear; level-mode bits hold no state.
    lat_d    = edge_q & (rise[7:0] | (lat_q & ~clr));
    enable_d = (wr && off == OFF_ENABLE) ? DI : enable_q;
    edge_d   = (wr && off == OFF_EDGE) ? DI : edge_q;
    nmi_d    = rise[8] | (nmi_q & ~(wr && off == OFF_NMICTL && DI[0]));
    irq_d    = |qual;

    sel_d = rd;
    do_d  = 8'h00;
    if (rd) begin
      case (off)
        OFF_STATUS: do_d = pend;
        OFF_ENABLE: do_d = enable_q;
        OFF_EDGE:   do_d = edge_q;
        OFF_VECTOR: do_d = vector;
        OFF_NMICTL: do_d = {7'b0, nmi_q};
        default:    do_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s1_q     <= 9'h000;
      s2_q     <= 9'h000;
      s3_q     <= 9'h000;
      lat_q    <= 8'h00;
      enable_q <= 8'h00;
      edge_q   <= 8'h00;
      do_q     <= 8'h00;
      nmi_q    <= 1'b0;
      irq_q    <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      s1_q     <= {NMI_SRC, SRC};
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      lat_q    <= lat_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      do_q     <= do_d;
      nmi_q    <= nmi_d;
      irq_q    <= irq_d;
      sel_q    <= sel_d;
    end
  end

  assign DO  = do_q;
  assign SEL = sel_q;
  assign IRQ = irq_q;
  assign NMI = nmi_q;

endmodule
`default_nettype wire
